// File: rtl/gameend_pkg.sv
// Shared definitions for the end-of-round sequencer.
//   state_e        : sequencer states (PLAY/SETTLE/SLIDE/HOLD/RESTART)
//   WIN_P1/WIN_P2/DRAW : encodings driven on the 'which' output
//   H_RES/V_RES    : visible screen size in pixels
//   cnt_width()    : bit width needed to hold 0..max inclusive
package gameend_pkg;

    typedef enum logic [2:0] {
        ST_PLAY,
        ST_SETTLE,
        ST_SLIDE,
        ST_HOLD,
        ST_RESTART
    } state_e;

    localparam logic [1:0] WIN_P1 = 2'd0;
    localparam logic [1:0] WIN_P2 = 2'd1;
    localparam logic [1:0] DRAW   = 2'd2;

    localparam int unsigned H_RES = 640;
    localparam int unsigned V_RES = 480;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/gameend_ctrl_if.sv
// Signal bundle between the end-of-round sequencer and its neighbours
// (game logic / collision on the input side, paint mux on the output side).
//   master : the sequencer (consumes tick/deaths/button, drives results)
//   slave  : the surrounding system (drives tick/deaths/button)
interface gameend_ctrl_if;

    logic       frame_tick;
    logic       p1_dead;
    logic       p2_dead;
    logic       restart_btn;
    logic [1:0] which;
    logic       show_end;
    logic [9:0] p_x;
    logic [9:0] p_y;
    logic       freeze;
    logic       game_rst;
    logic       busy;

    modport master (
        input  frame_tick, p1_dead, p2_dead, restart_btn,
        output which, show_end, p_x, p_y, freeze, game_rst, busy
    );

    modport slave (
        output frame_tick, p1_dead, p2_dead, restart_btn,
        input  which, show_end, p_x, p_y, freeze, game_rst, busy
    );

endinterface

// File: rtl/gameend_ctrl_frame_counter.sv
// Saturating frame counter.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : count enable (frame_tick)
//   count    : current value, saturates at MAX_COUNT
module frame_counter
    import gameend_pkg::*;
#(
    parameter int unsigned MAX_COUNT = 8,
    localparam int unsigned W = cnt_width(MAX_COUNT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_V = W'(MAX_COUNT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q < MAX_V)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/gameend_ctrl.sv
// End-of-round sequencer: resolves the round result from player deaths,
// freezes gameplay, slides the end image in, and hands restart back to play.
//   clk, rst : pixel clock, async active-high reset
//   bus      : gameend_ctrl_if.master
//              in : frame_tick, p1_dead, p2_dead, restart_btn
//              out: which, show_end, p_x, p_y, freeze, game_rst, busy
// All outputs are registered.
module gameend_ctrl
    import gameend_pkg::*;
#(
    parameter int unsigned SETTLE_FRAMES   = 8,
    parameter int unsigned MIN_HOLD_FRAMES = 60,
    parameter int unsigned ORIGIN_X        = 192,
    parameter int unsigned START_Y         = 0,
    parameter int unsigned TARGET_Y        = 176,
    parameter int unsigned STEP_Y          = 8
) (
    input  logic          clk,
    input  logic          rst,
    gameend_ctrl_if.master bus
);

    localparam int unsigned SW = cnt_width(SETTLE_FRAMES);
    localparam int unsigned HW = cnt_width(MIN_HOLD_FRAMES);

    state_e     state_q,    state_d;
    logic [1:0] which_q,    which_d;
    logic       show_end_q, show_end_d;
    logic [9:0] p_y_q,      p_y_d;
    logic       freeze_q,   freeze_d;
    logic       game_rst_q, game_rst_d;
    logic       busy_q,     busy_d;
    logic       btn_q;

    logic [SW-1:0] settle_cnt;
    logic [HW-1:0] hold_cnt;
    logic [10:0]   y_sum;
    logic          btn_rise;

    // Counters are held clear outside their state, so the tick that arrives
    // with the PLAY->SETTLE (or SLIDE->HOLD) transition is never counted.
    frame_counter #(.MAX_COUNT(SETTLE_FRAMES)) u_settle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_q != ST_SETTLE),
        .en    (bus.frame_tick),
        .count (settle_cnt)
    );

    frame_counter #(.MAX_COUNT(MIN_HOLD_FRAMES)) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_q != ST_HOLD),
        .en    (bus.frame_tick),
        .count (hold_cnt)
    );

    // 11-bit sum so a step past the target can be detected before clamping.
    assign y_sum    = {1'b0, p_y_q} + 11'(STEP_Y);
    assign btn_rise = bus.restart_btn && !btn_q;

    always_comb begin
        state_d    = state_q;
        which_d    = which_q;
        show_end_d = show_end_q;
        p_y_d      = p_y_q;
        freeze_d   = freeze_q;
        game_rst_d = 1'b0;
        busy_d     = busy_q;

        unique case (state_q)
            ST_PLAY: begin
                if (bus.p1_dead || bus.p2_dead) begin
                    state_d  = ST_SETTLE;
                    freeze_d = 1'b1;
                    busy_d   = 1'b1;
                    if (bus.p1_dead && bus.p2_dead) which_d = DRAW;
                    else if (bus.p2_dead)           which_d = WIN_P1;
                    else                            which_d = WIN_P2;
                end
            end
            ST_SETTLE: begin
                // Late death of the surviving player turns the result into a draw.
                if ((which_q == WIN_P1 && bus.p1_dead) ||
                    (which_q == WIN_P2 && bus.p2_dead)) begin
                    which_d = DRAW;
                end
                if (bus.frame_tick && (settle_cnt == SW'(SETTLE_FRAMES - 1))) begin
                    state_d    = ST_SLIDE;
                    show_end_d = 1'b1;
                    p_y_d      = 10'(START_Y);
                end
            end
            ST_SLIDE: begin
                if (bus.frame_tick) begin
                    if (y_sum >= 11'(TARGET_Y)) begin
                        p_y_d   = 10'(TARGET_Y);
                        state_d = ST_HOLD;
                    end else begin
                        p_y_d = y_sum[9:0];
                    end
                end
            end
            ST_HOLD: begin
                if (btn_rise && (hold_cnt == HW'(MIN_HOLD_FRAMES))) begin
                    state_d    = ST_RESTART;
                    game_rst_d = 1'b1;
                    show_end_d = 1'b0;
                    p_y_d      = 10'(START_Y);
                end
            end
            ST_RESTART: begin
                state_d  = ST_PLAY;
                freeze_d = 1'b0;
                busy_d   = 1'b0;
            end
            default: begin
                state_d = ST_PLAY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_PLAY;
            which_q    <= WIN_P1;
            show_end_q <= 1'b0;
            p_y_q      <= 10'(START_Y);
            freeze_q   <= 1'b0;
            game_rst_q <= 1'b0;
            busy_q     <= 1'b0;
            btn_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            which_q    <= which_d;
            show_end_q <= show_end_d;
            p_y_q      <= p_y_d;
            freeze_q   <= freeze_d;
            game_rst_q <= game_rst_d;
            busy_q     <= busy_d;
            btn_q      <= bus.restart_btn;
        end
    end

    assign bus.which    = which_q;
    assign bus.show_end = show_end_q;
    assign bus.p_x      = 10'(ORIGIN_X);
    assign bus.p_y      = p_y_q;
    assign bus.freeze   = freeze_q;
    assign bus.game_rst = game_rst_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_gameend_ctrl.sv
// Directed bench for gameend_ctrl: a default instance plus a STEP_Y=50
// instance sharing the same stimulus.
module tb_gameend_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_pass  = 0;
    int   gr_count = 0;

    gameend_ctrl_if bus ();
    gameend_ctrl_if bus2 ();

    assign bus2.frame_tick  = bus.frame_tick;
    assign bus2.p1_dead     = bus.p1_dead;
    assign bus2.p2_dead     = bus.p2_dead;
    assign bus2.restart_btn = bus.restart_btn;

    gameend_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    gameend_ctrl #(.STEP_Y(50)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.game_rst === 1'b1) gr_count++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic frame();
        bus.frame_tick = 1'b1;
        cyc();
        bus.frame_tick = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        bus.frame_tick  = 1'b0;
        bus.p1_dead     = 1'b0;
        bus.p2_dead     = 1'b0;
        bus.restart_btn = 1'b0;
        repeat (2) cyc();

        chk("rst_which",    32'(bus.which),    0);
        chk("rst_show_end", 32'(bus.show_end), 0);
        chk("rst_p_x",      32'(bus.p_x),      192);
        chk("rst_p_y",      32'(bus.p_y),      0);
        chk("rst_freeze",   32'(bus.freeze),   0);
        chk("rst_game_rst", 32'(bus.game_rst), 0);
        chk("rst_busy",     32'(bus.busy),     0);
        rst = 1'b0;
        cyc();

        // p2 dies; a frame_tick in the same cycle must not count
        bus.p2_dead    = 1'b1;
        bus.frame_tick = 1'b1;
        cyc();
        bus.p2_dead    = 1'b0;
        bus.frame_tick = 1'b0;
        chk("s1_which",    32'(bus.which),    0);
        chk("s1_freeze",   32'(bus.freeze),   1);
        chk("s1_busy",     32'(bus.busy),     1);
        chk("s1_show_end", 32'(bus.show_end), 0);
        cyc();
        repeat (7) frame();
        chk("settle7_show_end", 32'(bus.show_end), 0);
        frame();
        chk("settle8_show_end", 32'(bus.show_end), 1);
        chk("slide_start_p_y",  32'(bus.p_y),      0);
        chk("slide_start_p_y50", 32'(bus2.p_y),    0);

        // button held from before HOLD entry: no edge seen inside HOLD
        bus.restart_btn = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            frame();
            chk("slide_p_y", 32'(bus.p_y), 32'(8 * k));
            if (k <= 5) chk("slide50_p_y", 32'(bus2.p_y), (50 * k > 176) ? 32'd176 : 32'(50 * k));
        end
        chk("hold_busy", 32'(bus.busy), 1);

        repeat (30) frame();
        #1;
        chk("held_btn_no_rst", 32'(gr_count), 0);
        cyc();
        bus.restart_btn = 1'b0;
        cyc();
        bus.restart_btn = 1'b1;
        cyc();
        chk("early_press_game_rst", 32'(bus.game_rst), 0);
        chk("early_press_show_end", 32'(bus.show_end), 1);
        bus.restart_btn = 1'b0;
        cyc();

        bus.p1_dead = 1'b1;
        frame();
        chk("hold_death_which",    32'(bus.which),    0);
        chk("hold_death_show_end", 32'(bus.show_end), 1);
        chk("hold_death_p_y",      32'(bus.p_y),      176);
        chk("hold_death_game_rst", 32'(bus.game_rst), 0);
        bus.p1_dead = 1'b0;

        repeat (35) frame();
        bus.restart_btn = 1'b1;
        cyc();
        chk("restart_game_rst", 32'(bus.game_rst), 1);
        chk("restart_show_end", 32'(bus.show_end), 0);
        chk("restart_p_y",      32'(bus.p_y),      0);
        chk("restart_busy",     32'(bus.busy),     1);
        bus.restart_btn = 1'b0;
        cyc();
        chk("play_game_rst", 32'(bus.game_rst), 0);
        chk("play_freeze",   32'(bus.freeze),   0);
        chk("play_busy",     32'(bus.busy),     0);
        #1;
        chk("single_pulse", 32'(gr_count), 1);
        cyc();

        // p1 first, p2 three frames later -> draw
        bus.p1_dead = 1'b1;
        cyc();
        chk("s2_which_p2win", 32'(bus.which), 1);
        repeat (3) frame();
        bus.p2_dead = 1'b1;
        cyc();
        chk("s2_which_draw", 32'(bus.which), 2);
        repeat (4) frame();
        chk("s2_settle_show_end", 32'(bus.show_end), 0);
        frame();
        chk("s2_slide_show_end", 32'(bus.show_end), 1);
        chk("s2_slide_which",    32'(bus.which),    2);
        bus.p1_dead = 1'b0;
        bus.p2_dead = 1'b0;
        repeat (12) frame();
        chk("s2_mid_p_y",  32'(bus.p_y),   96);
        chk("s2_mid_which", 32'(bus.which), 2);

        // asynchronous reset mid-slide
        #2;
        rst = 1'b1;
        #1;
        chk("arst_which",    32'(bus.which),    0);
        chk("arst_show_end", 32'(bus.show_end), 0);
        chk("arst_p_y",      32'(bus.p_y),      0);
        chk("arst_freeze",   32'(bus.freeze),   0);
        chk("arst_busy",     32'(bus.busy),     0);
        chk("arst_game_rst", 32'(bus.game_rst), 0);
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        #1;
        chk("arst_no_pulse", 32'(gr_count), 1);
        cyc();

        // simultaneous deaths -> draw
        bus.p1_dead = 1'b1;
        bus.p2_dead = 1'b1;
        cyc();
        chk("s3_which",  32'(bus.which),  2);
        chk("s3_freeze", 32'(bus.freeze), 1);
        bus.p1_dead = 1'b0;
        bus.p2_dead = 1'b0;
        repeat (8) frame();
        chk("s3_show_end", 32'(bus.show_end), 1);
        chk("s3_which_slide", 32'(bus.which), 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
